// File: rtl/chip8_alu_seq_pkg.sv
// rtl/chip8_alu_seq_pkg.sv - shared ALU opcode enum and sequencer state encoding
package chip8_alu_seq_pkg;

  typedef enum logic [3:0] {
    ALU_OR      = 4'd0,
    ALU_AND     = 4'd1,
    ALU_XOR     = 4'd2,
    ALU_ADD     = 4'd3,
    ALU_MINUS   = 4'd4,
    ALU_EQUALS  = 4'd5,
    ALU_GREATER = 4'd6,
    ALU_INC     = 4'd7,
    ALU_NOP     = 4'd8,
    ALU_LSHIFT  = 4'd9,
    ALU_RSHIFT  = 4'd10
  } ALU_f;

  typedef logic [1:0] alu_state_t;

  localparam alu_state_t ST_IDLE  = 2'd0;
  localparam alu_state_t ST_SHIFT = 2'd1;
  localparam alu_state_t ST_DONE  = 2'd2;

  // Shifts are the only multi-cycle operations.
  function automatic logic is_shift(input ALU_f op);
    return (op == ALU_LSHIFT) || (op == ALU_RSHIFT);
  endfunction

endpackage

// File: rtl/chip8_alu_core.sv
// rtl/chip8_alu_core.sv - combinational single-cycle Chip8 ALU operations
module chip8_alu_core
  import chip8_alu_seq_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CARRY_BIT = 8
) (
  input  ALU_f             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   carry_mask;
  logic [WIDTH-1:0] one;

  assign sum        = {1'b0, a_i} + {1'b0, b_i};
  assign carry_mask = {{WIDTH{1'b0}}, 1'b1} << CARRY_BIT;
  assign one        = {{(WIDTH-1){1'b0}}, 1'b1};

  // Select the operation result; carry is only meaningful for ADD and MINUS.
  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    case (op_i)
      ALU_OR:      result_o = a_i | b_i;
      ALU_AND:     result_o = a_i & b_i;
      ALU_XOR:     result_o = a_i ^ b_i;
      ALU_ADD: begin
        result_o = sum[WIDTH-1:0];
        carry_o  = |(sum & carry_mask);
      end
      ALU_MINUS: begin
        result_o = a_i - b_i;
        carry_o  = (a_i < b_i);
      end
      ALU_EQUALS:  result_o = (a_i == b_i) ? one : '0;
      ALU_GREATER: result_o = (a_i > b_i) ? one : '0;
      ALU_INC:     result_o = a_i + one;
      default:     result_o = '0;
    endcase
  end

endmodule

// File: rtl/chip8_alu_seq.sv
// rtl/chip8_alu_seq.sv - registered Chip8 ALU with valid/ready handshakes and serial shifter
module chip8_alu_seq
  import chip8_alu_seq_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CARRY_BIT = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  ALU_f             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             busy
);

  localparam int SHAMT_W = $clog2(WIDTH);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic             left_q, left_d;

  logic [WIDTH-1:0]   core_result;
  logic               core_carry;
  logic [SHAMT_W-1:0] shamt;
  logic               accept;

  chip8_alu_core #(
    .WIDTH     (WIDTH),
    .CARRY_BIT (CARRY_BIT)
  ) u_core (
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .result_o (core_result),
    .carry_o  (core_carry)
  );

  assign shamt     = b[SHAMT_W-1:0];
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_SHIFT);
  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign result    = result_q;
  assign carry     = carry_q;

  // Next-state logic: result_q doubles as the shift working register, since
  // out_valid is low for the whole SHIFT phase.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    left_d   = left_q;

    case (state_q)
      ST_SHIFT: begin
        if (left_q) begin
          result_d = {result_q[WIDTH-2:0], 1'b0};
          carry_d  = result_q[WIDTH-1];
        end else begin
          result_d = {1'b0, result_q[WIDTH-1:1]};
          carry_d  = result_q[0];
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready && !in_valid) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new beat overrides the above; it only happens from IDLE or a consumed DONE.
    if (accept) begin
      if (is_shift(op)) begin
        left_d   = (op == ALU_LSHIFT);
        result_d = a;
        carry_d  = 1'b0;
        cnt_d    = shamt;
        state_d  = (shamt == '0) ? ST_DONE : ST_SHIFT;
      end else begin
        result_d = core_result;
        carry_d  = core_carry;
        state_d  = ST_DONE;
      end
    end
  end

  // State and output registers; reset abandons any shift in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
    end
  end

endmodule

// File: tb/tb_chip8_alu_seq.sv
// tb/tb_chip8_alu_seq.sv - self-checking bench for chip8_alu_seq
module tb_chip8_alu_seq;
  import chip8_alu_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, carry, busy;
  ALU_f        op;
  logic [15:0] a, b, result;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_carry, w_busy;
  ALU_f        w_op;
  logic [31:0] w_a, w_b, w_result;

  chip8_alu_seq #(.WIDTH(16), .CARRY_BIT(8)) dut (
    .clk(clk), .reset_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry(carry), .busy(busy)
  );

  chip8_alu_seq #(.WIDTH(32), .CARRY_BIT(8)) dut32 (
    .clk(clk), .reset_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready), .op(w_op),
    .a(w_a), .b(w_b), .out_valid(w_out_valid), .out_ready(w_out_ready), .result(w_result),
    .carry(w_carry), .busy(w_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_op(input ALU_f o, input logic [15:0] va, input logic [15:0] vb,
                       output logic [15:0] r, output logic c, output int lat, output int nbusy);
    int guard;
    @(negedge clk);
    op = o; a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0; nbusy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
    end while (!out_valid && lat < 100);
    r = result; c = carry;
  endtask

  task automatic do_op32(input ALU_f o, input logic [31:0] va, input logic [31:0] vb,
                         output logic [31:0] r, output logic c, output int lat);
    int guard;
    @(negedge clk);
    w_op = o; w_a = va; w_b = vb; w_in_valid = 1'b1; w_out_ready = 1'b1;
    guard = 0;
    while (!w_in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 w_in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!w_out_valid && lat < 100);
    r = w_result; c = w_carry;
  endtask

  typedef struct {
    ALU_f        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic        c;
    int          lat;
  } vec_t;

  vec_t tv[19];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    logic        c;
    int          lat, nb, seen;
    logic [31:0] r32;
    logic        c32;
    ALU_f        bop[4];
    logic [15:0] ba[4], bb[4], br[4];

    tv[0]  = '{ALU_OR,      16'hF5A0, 16'hFA50, 16'hFFF0, 1'b0, 1};
    tv[1]  = '{ALU_AND,     16'hF5A0, 16'hFA50, 16'hF000, 1'b0, 1};
    tv[2]  = '{ALU_XOR,     16'hF5A0, 16'hFA50, 16'h0FF0, 1'b0, 1};
    tv[3]  = '{ALU_ADD,     16'd180,  16'd180,  16'd360,  1'b1, 1};
    tv[4]  = '{ALU_ADD,     16'd5,    16'd5,    16'd10,   1'b0, 1};
    tv[5]  = '{ALU_MINUS,   16'h7003, 16'hE0A5, 16'd36702, 1'b1, 1};
    tv[6]  = '{ALU_MINUS,   16'h1234, 16'h1234, 16'h0000, 1'b0, 1};
    tv[7]  = '{ALU_EQUALS,  16'd8,    16'd9,    16'd0,    1'b0, 1};
    tv[8]  = '{ALU_GREATER, 16'd5,    16'd3,    16'd1,    1'b0, 1};
    tv[9]  = '{ALU_GREATER, 16'd3,    16'd5,    16'd0,    1'b0, 1};
    tv[10] = '{ALU_INC,     16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1};
    tv[11] = '{ALU_NOP,     16'h1234, 16'h5678, 16'h0000, 1'b0, 1};
    tv[12] = '{ALU_LSHIFT,  16'h0031, 16'd2,    16'h00C4, 1'b0, 3};
    tv[13] = '{ALU_RSHIFT,  16'h1111, 16'd1,    16'h0888, 1'b1, 2};
    tv[14] = '{ALU_LSHIFT,  16'hABCD, 16'd0,    16'hABCD, 1'b0, 1};
    tv[15] = '{ALU_RSHIFT,  16'hABCD, 16'h0010, 16'hABCD, 1'b0, 1};
    tv[16] = '{ALU_ADD,     16'h0080, 16'h0080, 16'h0100, 1'b1, 1};
    tv[17] = '{ALU_LSHIFT,  16'h8001, 16'd15,   16'h8000, 1'b0, 16};
    tv[18] = '{ALU_RSHIFT,  16'h4000, 16'd15,   16'h0000, 1'b1, 16};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = ALU_NOP; a = '0; b = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b1; w_op = ALU_NOP; w_a = '0; w_b = '0;
    repeat (2) @(negedge clk);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset result", {16'd0, result}, 32'd0);
    chk("reset carry", {31'd0, carry}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;

    // Table of single operations, each fully drained.
    for (int i = 0; i < 19; i++) begin
      do_op(tv[i].op, tv[i].a, tv[i].b, r, c, lat, nb);
      chk($sformatf("vec%0d result", i), {16'd0, r}, {16'd0, tv[i].r});
      chk($sformatf("vec%0d carry", i), {31'd0, c}, {31'd0, tv[i].c});
      chk($sformatf("vec%0d latency", i), lat, tv[i].lat);
      chk($sformatf("vec%0d busy_cycles", i), nb, tv[i].lat - 1);
    end

    // Back-to-back stream with out_ready held high.
    bop[0] = ALU_ADD; ba[0] = 16'd1;    bb[0] = 16'd2;    br[0] = 16'd3;
    bop[1] = ALU_XOR; ba[1] = 16'h00FF; bb[1] = 16'h0F0F; br[1] = 16'h0FF0;
    bop[2] = ALU_INC; ba[2] = 16'd7;    bb[2] = 16'd0;    br[2] = 16'd8;
    bop[3] = ALU_OR;  ba[3] = 16'h1000; bb[3] = 16'h0001; br[3] = 16'h1001;
    out_ready = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("b2b%0d out_valid", i - 1), {31'd0, out_valid}, 32'd1);
        chk($sformatf("b2b%0d result", i - 1), {16'd0, result}, {16'd0, br[i-1]});
      end
      if (i < 4) begin
        op = bop[i]; a = ba[i]; b = bb[i]; in_valid = 1'b1;
        chk($sformatf("b2b%0d in_ready", i), {31'd0, in_ready}, 32'd1);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b drained", {31'd0, out_valid}, 32'd0);

    // Backpressure: EQUALS 8/8 held while a new beat waits.
    out_ready = 1'b0;
    op = ALU_EQUALS; a = 16'd8; b = 16'd8; in_valid = 1'b1;
    @(posedge clk);
    #1 op = ALU_ADD; a = 16'd2; b = 16'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp%0d result", i), {16'd0, result}, 32'd1);
      chk($sformatf("bp%0d in_ready", i), {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp next out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp next result", {16'd0, result}, 32'd5);
    @(negedge clk);
    chk("bp drained", {31'd0, out_valid}, 32'd0);

    // INC chain from 8, seventeen steps.
    r = 16'd8;
    for (int i = 0; i < 17; i++) begin
      do_op(ALU_INC, r, 16'd0, r, c, lat, nb);
    end
    chk("inc chain result", {16'd0, r}, 32'd25);

    // Reset during a long shift.
    @(negedge clk);
    op = ALU_LSHIFT; a = 16'h0031; b = 16'd15; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midshift busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midshift rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("midshift rst result", {16'd0, result}, 32'd0);
    chk("midshift rst carry", {31'd0, carry}, 32'd0);
    chk("midshift rst busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("midshift in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midshift no beat", seen, 0);

    // Wide instance.
    do_op32(ALU_MINUS, 32'd0, 32'd1, r32, c32, lat);
    chk("w32 minus result", r32, 32'hFFFF_FFFF);
    chk("w32 minus carry", {31'd0, c32}, 32'd1);
    do_op32(ALU_LSHIFT, 32'h8000_0000, 32'd1, r32, c32, lat);
    chk("w32 lshift result", r32, 32'd0);
    chk("w32 lshift carry", {31'd0, c32}, 32'd1);
    chk("w32 lshift latency", lat, 2);
    do_op32(ALU_LSHIFT, 32'd1, 32'd33, r32, c32, lat);
    chk("w32 shamt mask result", r32, 32'd2);
    chk("w32 shamt mask latency", lat, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
